// File: rtl/flash_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : flash_port_arbiter_if
//  Purpose  : Bundles the requester-side and flash-side signals of the flash
//             read-port arbiter.
//  Ports    : reqEnable/reqAddress/reqBusy/reqDataRead   - three requesters
//             flashEnable/flashAddress/flashDataRead/flashBusy - flash port
//             timeoutError/currentOwner                     - status
//  Modports : slave  - the arbiter itself
//             master - the fabric/flash side (environment)
//  Revision : 1.0  initial release
// ============================================================================
interface flash_port_arbiter_if #(
    parameter int ADDRESS_WIDTH = 24
);
    logic [2:0]                   reqEnable;
    logic [3*ADDRESS_WIDTH-1:0]   reqAddress;
    logic [2:0]                   reqBusy;
    logic [31:0]                  reqDataRead;
    logic                         flashEnable;
    logic [ADDRESS_WIDTH-1:0]     flashAddress;
    logic [31:0]                  flashDataRead;
    logic                         flashBusy;
    logic                         timeoutError;
    logic [1:0]                   currentOwner;

    modport slave (
        input  reqEnable, reqAddress, flashDataRead, flashBusy,
        output reqBusy, reqDataRead, flashEnable, flashAddress,
               timeoutError, currentOwner
    );

    modport master (
        output reqEnable, reqAddress, flashDataRead, flashBusy,
        input  reqBusy, reqDataRead, flashEnable, flashAddress,
               timeoutError, currentOwner
    );
endinterface
`default_nettype wire

// File: rtl/flash_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : flash_port_arbiter
//  Purpose  : Round-robin arbiter sharing the flash page-cache read port among
//             three requesters (0 = core0 ifetch, 1 = core0 data,
//             2 = wishbone management), with a watchdog on a stuck flash port.
//  Ports    : clk  - system clock
//             rst  - asynchronous active-low reset
//             bus  - flash_port_arbiter_if.slave (requesters + flash port)
//  Params   : ADDRESS_WIDTH  - address width forwarded to the flash port
//             TIMEOUT_CYCLES - ACTIVE cycles before forced abort, 0 = off
//  Revision : 1.0  initial release
// ============================================================================
module flash_port_arbiter #(
    parameter int ADDRESS_WIDTH  = 24,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    flash_port_arbiter_if.slave   bus
);

    localparam logic [0:0] c_IDLE   = 1'b0;
    localparam logic [0:0] c_ACTIVE = 1'b1;

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic c_WDOG_EN = (TIMEOUT_CYCLES > 0);

    logic [0:0]               state_q, state_d;
    logic [1:0]               ptr_q, ptr_d;
    logic [1:0]               owner_q, owner_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;

    logic                     w_active;
    logic                     w_grant_vld;
    logic [1:0]               w_grant_idx;
    logic [ADDRESS_WIDTH-1:0] w_grant_addr;
    logic                     w_timeout;
    logic                     w_done;
    logic [2:0]               w_owner_oh;

    // (base + offs) mod 3 for base, offs in 0..2
    function automatic logic [1:0] f_rr_index(input logic [1:0] base,
                                              input logic [1:0] offs);
        logic [2:0] sum;
        sum = {1'b0, base} + {1'b0, offs};
        f_rr_index = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
    endfunction

    assign w_active = (state_q == c_ACTIVE);

    // Scan from the far end back toward the pointer so the candidate closest
    // to the pointer is the last one written and therefore wins.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = 2'd0;
        for (int k = 2; k >= 0; k--) begin
            if (bus.reqEnable[f_rr_index(ptr_q, 2'(k))]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = f_rr_index(ptr_q, 2'(k));
            end
        end
    end

    always_comb begin
        w_grant_addr = '0;
        case (w_grant_idx)
            2'd0:    w_grant_addr = bus.reqAddress[0*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            2'd1:    w_grant_addr = bus.reqAddress[1*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            default: w_grant_addr = bus.reqAddress[2*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        endcase
    end

    // Watchdog fires only while the flash is still busy; a normal completion
    // landing in the last allowed cycle takes precedence.
    assign w_timeout  = w_active && c_WDOG_EN && bus.flashBusy && (cnt_q == c_CNT_LAST);
    assign w_done     = w_active && (!bus.flashBusy || w_timeout);
    assign w_owner_oh = 3'(3'b001 << owner_q);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        case (state_q)
            c_IDLE: begin
                cnt_d = '0;
                if (w_grant_vld) begin
                    state_d = c_ACTIVE;
                    owner_d = w_grant_idx;
                    addr_d  = w_grant_addr;
                    ptr_d   = (w_grant_idx == 2'd2) ? 2'd0 : w_grant_idx + 2'd1;
                end
            end
            c_ACTIVE: begin
                if (w_done) begin
                    state_d = c_IDLE;
                    cnt_d   = '0;
                end else if (bus.flashBusy) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= c_IDLE;
            ptr_q   <= 2'd0;
            owner_q <= 2'd0;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.flashEnable  = w_active;
    assign bus.flashAddress = addr_q;
    assign bus.currentOwner = w_active ? owner_q : 2'b11;
    assign bus.timeoutError = w_timeout;
    assign bus.reqBusy      = bus.reqEnable & ~(w_done ? w_owner_oh : 3'b000);
    assign bus.reqDataRead  = !w_done   ? 32'h0000_0000 :
                              w_timeout ? 32'hFFFF_FFFF : bus.flashDataRead;

endmodule
`default_nettype wire
